// File: rtl/riscv_ifetch_pkg.sv
// Shared types and constants for the instruction prefetch unit and its FIFO.
// Also holds the build-time defaults for FIFO depth and reset PC.
package riscv_ifetch_pkg;

    localparam int unsigned IF_DEPTH_DEFAULT   = 4;
    localparam logic [31:0] IF_RESETPC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DROPW = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/riscv_ififo.sv
// 64-bit wide synchronous FIFO holding {PC, instruction} pairs.
// Flush empties the FIFO and has priority over push and pop.
module riscv_ififo
    import riscv_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ifq_entry_t push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [AW:0] count,
    output ifq_entry_t head
);

    ifq_entry_t      mem_q [DEPTH];
    ifq_entry_t      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !flush && (count_q != '0);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction prefetch unit: issues sequential word fetches to the BRAM
// instruction port, queues {PC, word} and drops stale responses on redirect.
module riscv_ifetch
    import riscv_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH   = IF_DEPTH_DEFAULT,
    parameter logic [31:0] RESETPC = IF_RESETPC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        HLT,
    input  logic        FLUSH,
    input  logic [31:0] FPC,
    input  logic        IPOP,
    output logic        IRDY,
    output logic [31:0] IPC,
    output logic [31:0] IINST,
    output logic        IDREQ,
    output logic [31:0] IADDR,
    input  logic [31:0] IDATA,
    input  logic        IDACK
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;

    logic [AW:0] count;
    logic [AW:0] count_after;
    ifq_entry_t  head;
    ifq_entry_t  push_data;
    logic        push;
    logic        pop;
    logic        issue_now;
    logic        issue_after;

    riscv_ififo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RES),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (FLUSH),
        .count    (count),
        .head     (head)
    );

    always_comb begin
        push      = (state_q == ST_REQ) && IDACK && !FLUSH;
        pop       = IPOP && IRDY && !FLUSH;
        push_data = '{pc: npc_q, inst: IDATA};

        count_after = count;
        if (push && !pop) begin
            count_after = count + 1'b1;
        end else if (!push && pop) begin
            count_after = count - 1'b1;
        end

        issue_now   = !HLT && (count < FULL);
        issue_after = !HLT && (count_after < FULL);

        state_d = state_q;
        npc_d   = npc_q;
        addr_d  = addr_q;
        req_d   = req_q;

        if (FLUSH) begin
            npc_d = FPC;
            // An unacked request cannot be withdrawn: keep it on the bus and
            // wait out its response; otherwise the target can go out at once.
            if (state_q == ST_REQ && !IDACK) begin
                state_d = ST_DROPW;
            end else if (state_q == ST_DROPW && !IDACK) begin
                state_d = ST_DROPW;
            end else if (!HLT) begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = FPC;
            end else begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_now) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = npc_q;
                    end
                end
                ST_REQ: begin
                    if (IDACK) begin
                        npc_d = pc_next(npc_q);
                        if (issue_after) begin
                            req_d  = 1'b1;
                            addr_d = pc_next(npc_q);
                        end else begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                ST_DROPW: begin
                    if (IDACK) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
            npc_q   <= RESETPC;
            addr_q  <= RESETPC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign IRDY  = (count != '0);
    assign IPC   = head.pc;
    assign IINST = head.inst;
    assign IDREQ = req_q;
    assign IADDR = addr_q;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch against a wait-state BRAM model (word[i]=i);
// popped entries are scored against a queue of expected PCs.
module tb_riscv_ifetch;

    logic        CLK;
    logic        RES;
    logic        HLT;
    logic        FLUSH;
    logic [31:0] FPC;
    logic        IPOP;
    logic        IRDY;
    logic [31:0] IPC;
    logic [31:0] IINST;
    logic        IDREQ;
    logic [31:0] IADDR;
    logic [31:0] IDATA;
    logic        IDACK;

    int unsigned wait_n;
    int unsigned mcnt;
    logic [31:0] exp_q[$];
    logic [31:0] acks[$];
    int          total;
    int          bad;
    int          pops;

    riscv_ifetch #(
        .DEPTH  (4),
        .RESETPC(32'h0000_0000)
    ) dut (
        .CLK  (CLK),
        .RES  (RES),
        .HLT  (HLT),
        .FLUSH(FLUSH),
        .FPC  (FPC),
        .IPOP (IPOP),
        .IRDY (IRDY),
        .IPC  (IPC),
        .IINST(IINST),
        .IDREQ(IDREQ),
        .IADDR(IADDR),
        .IDATA(IDATA),
        .IDACK(IDACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // BRAM with registered ack: wait_n cycles of IDREQ, then one ack cycle
    always @(posedge CLK or posedge RES) begin
        if (RES) begin
            IDACK <= 1'b0;
            IDATA <= '0;
            mcnt  <= 0;
        end else if (IDACK) begin
            IDACK <= 1'b0;
            mcnt  <= 0;
        end else if (IDREQ) begin
            if (mcnt + 1 >= wait_n) begin
                IDACK <= 1'b1;
                IDATA <= IADDR >> 2;
                mcnt  <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        logic [31:0] e;
        chk("pop_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", IPC, e);
            chk("pop_inst", IINST, e >> 2);
        end
        pops++;
    endtask

    task automatic tick();
        if (IPOP && IRDY && !FLUSH && !RES) check_pop();
        @(posedge CLK);
        #1;
        if (IDACK) acks.push_back(IADDR);
    endtask

    task automatic do_reset();
        RES = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        acks.delete();
        RES = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    initial begin
        int          p0;
        int          idle;
        int          max_idle;
        bit          started;
        bit          seen_rdy;
        bit          saw_req;
        logic [31:0] first_pc;
        logic [31:0] first_inst;

        total = 0; bad = 0; pops = 0;
        RES = 1'b1; HLT = 1'b0; FLUSH = 1'b0; FPC = '0; IPOP = 1'b0;
        wait_n = 1;

        // reset state
        @(posedge CLK);
        #1;
        chk("rst_idreq", IDREQ, 0);
        chk("rst_iaddr", IADDR, 32'h0);
        chk("rst_irdy", IRDY, 0);
        chk("rst_ipc", IPC, 32'h0);
        chk("rst_iinst", IINST, 32'h0);

        // A: W=1, popping every cycle
        exp_q.delete(); acks.delete();
        RES = 1'b0;
        IPOP = 1'b1;
        push_seq(32'h0, 16);
        tick();
        chk("a_first_idreq", IDREQ, 1);
        chk("a_first_iaddr", IADDR, 32'h0);
        p0 = pops; idle = 0; max_idle = 0; started = 0; seen_rdy = 0;
        first_pc = 'x; first_inst = 'x;
        for (int i = 0; i < 19; i++) begin
            if (IRDY && !seen_rdy) begin
                seen_rdy = 1; first_pc = IPC; first_inst = IINST;
            end
            if (IPOP && IRDY) begin
                if (started && idle > max_idle) max_idle = idle;
                idle = 0; started = 1;
            end else if (started) begin
                idle++;
            end
            tick();
        end
        chk("a_first_rdy_pc", first_pc, 32'h0);
        chk("a_first_rdy_inst", first_inst, 32'h0);
        chk("a_pop_count", pops - p0, 9);
        chk("a_max_gap", max_idle, 1);
        chk("a_ack_count_ge4", (acks.size() >= 4), 1);
        if (acks.size() >= 4) begin
            chk("a_ack0", acks[0], 32'h0);
            chk("a_ack1", acks[1], 32'h4);
            chk("a_ack2", acks[2], 32'h8);
            chk("a_ack3", acks[3], 32'hC);
        end
        IPOP = 1'b0;

        // B: no pops, FIFO fills to DEPTH then one pop frees one slot
        do_reset();
        push_seq(32'h0, 5);
        for (int i = 0; i < 20; i++) tick();
        chk("b_ack_count", acks.size(), 4);
        chk("b_full_idreq", IDREQ, 0);
        chk("b_full_irdy", IRDY, 1);
        IPOP = 1'b1;
        tick();
        IPOP = 1'b0;
        for (int n = 0; n < 10 && !IDREQ; n++) tick();
        chk("b_refill_req", IDREQ, 1);
        chk("b_refill_addr", IADDR, 32'h10);
        for (int i = 0; i < 10; i++) tick();
        chk("b_ack_count2", acks.size(), 5);
        chk("b_refull_idreq", IDREQ, 0);

        // C: W=3, flush to 0x100 while the fetch of 0x8 is waiting
        wait_n = 3;
        do_reset();
        for (int n = 0; n < 40 && !(IDREQ && IADDR == 32'h8); n++) tick();
        chk("c_req8_seen", (IDREQ && IADDR == 32'h8), 1);
        tick();
        FLUSH = 1'b1; FPC = 32'h100;
        tick();
        FLUSH = 1'b0; FPC = '0;
        chk("c_flush_irdy", IRDY, 0);
        chk("c_frozen_req", IDREQ, 1);
        chk("c_frozen_addr", IADDR, 32'h8);
        for (int n = 0; n < 20 && !IDACK; n++) tick();
        chk("c_stale_ack", IDACK, 1);
        chk("c_stale_addr", IADDR, 32'h8);
        tick();
        for (int n = 0; n < 20 && !IDREQ; n++) tick();
        chk("c_redirect_req", IDREQ, 1);
        chk("c_redirect_addr", IADDR, 32'h100);
        push_seq(32'h100, 8);
        IPOP = 1'b1;
        p0 = pops;
        for (int i = 0; i < 24; i++) tick();
        IPOP = 1'b0;
        chk("c_pops_ge3", (pops - p0 >= 3), 1);

        // D: W=1, flush coinciding with ack and pop
        wait_n = 1;
        do_reset();
        for (int n = 0; n < 40 && !(IDACK && IRDY); n++) tick();
        chk("d_ack_with_rdy", (IDACK && IRDY), 1);
        FLUSH = 1'b1; FPC = 32'h200; IPOP = 1'b1;
        tick();
        FLUSH = 1'b0; FPC = '0; IPOP = 1'b0;
        chk("d_flush_irdy", IRDY, 0);
        chk("d_redirect_req", IDREQ, 1);
        chk("d_redirect_addr", IADDR, 32'h200);
        push_seq(32'h200, 8);
        IPOP = 1'b1;
        p0 = pops;
        for (int i = 0; i < 12; i++) tick();
        IPOP = 1'b0;
        chk("d_pops_ge4", (pops - p0 >= 4), 1);

        // E: W=3, halt raised mid-request
        wait_n = 3;
        do_reset();
        tick();
        tick();
        HLT = 1'b1;
        for (int n = 0; n < 20 && !IDACK; n++) tick();
        chk("e_ack_under_hlt", IDACK, 1);
        tick();
        chk("e_stored_irdy", IRDY, 1);
        chk("e_stored_pc", IPC, 32'h0);
        saw_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (IDREQ) saw_req = 1;
            tick();
        end
        chk("e_no_req_hlt", saw_req, 0);
        HLT = 1'b0;
        tick();
        chk("e_resume_req", IDREQ, 1);
        chk("e_resume_addr", IADDR, 32'h4);

        // F: reset pulsed mid-request
        tick();
        RES = 1'b1;
        #1;
        chk("f_async_idreq", IDREQ, 0);
        chk("f_async_irdy", IRDY, 0);
        chk("f_async_iaddr", IADDR, 32'h0);
        @(posedge CLK);
        #1;
        exp_q.delete(); acks.delete();
        RES = 1'b0;
        tick();
        chk("f_restart_req", IDREQ, 1);
        chk("f_restart_addr", IADDR, 32'h0);
        push_seq(32'h0, 4);
        IPOP = 1'b1;
        p0 = pops;
        for (int i = 0; i < 12; i++) tick();
        IPOP = 1'b0;
        chk("f_pops_ge2", (pops - p0 >= 2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
